// File: rtl/seg_scan_ctrl_if.sv
// Bundle of key-event inputs, decoder loop-back and multiplexed display outputs
// shared by the scan controller and whatever drives and observes it.
interface seg_scan_ctrl_if;
    logic       key_on;
    logic       key_off;
    logic [7:0] key_note;
    logic [7:0] noteid;
    logic [8:0] seg1;
    logic [8:0] seg2;
    logic [7:0] seg_out;
    logic [1:0] dig_sel;
    logic       busy;

    modport master (
        output key_on, key_off, key_note, seg1, seg2,
        input  noteid, seg_out, dig_sel, busy
    );

    modport slave (
        input  key_on, key_off, key_note, seg1, seg2,
        output noteid, seg_out, dig_sel, busy
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Two-digit multiplexed note display: tracks the held/released key, feeds the
// external decoder via noteid and time-slices its patterns onto one segment bus.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int HOLD_CYC = 25000000
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

    state_t          state_reg;
    logic [7:0]      key_reg;
    logic            ovf_reg;
    logic [HW-1:0]   hold_reg;
    logic [SW-1:0]   scan_reg;
    logic            tens_reg;
    logic [7:0]      noteid_reg;
    logic [7:0]      seg_reg;
    logic [1:0]      dig_reg;
    logic            busy_reg;

    logic            valid_on;
    logic            off_match;
    logic            blank;
    logic [7:0]      clamped;
    logic            unused_bits;

    assign valid_on    = bus.key_on && (bus.key_note != 8'd0);
    // key_off is matched against the raw key so a clamped note can still be released
    assign off_match   = bus.key_off && (bus.key_note == key_reg);
    assign clamped     = (bus.key_note > 8'd99) ? 8'd99 : bus.key_note;
    assign blank       = (state_reg == IDLE) || (scan_reg == '0) ||
                         (tens_reg && (noteid_reg < 8'd10));
    assign unused_bits = bus.seg1[8] ^ bus.seg2[8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            key_reg    <= 8'd0;
            ovf_reg    <= 1'b0;
            hold_reg   <= '0;
            scan_reg   <= '0;
            tens_reg   <= 1'b1;
            noteid_reg <= 8'd0;
            seg_reg    <= 8'd0;
            dig_reg    <= 2'b11;
            busy_reg   <= 1'b0;
        end else begin
            if (scan_reg == SW'(SCAN_DIV - 1)) begin
                scan_reg <= '0;
                tens_reg <= ~tens_reg;
            end else begin
                scan_reg <= scan_reg + 1'b1;
            end

            // Decoder patterns belong to the current noteid, so sample them now
            if (blank) begin
                seg_reg <= 8'd0;
                dig_reg <= 2'b11;
            end else if (tens_reg) begin
                seg_reg <= {bus.seg1[7] | ovf_reg, bus.seg1[6:0]};
                dig_reg <= 2'b01;
            end else begin
                seg_reg <= bus.seg2[7:0];
                dig_reg <= 2'b10;
            end

            if (valid_on) begin
                state_reg  <= SHOW;
                key_reg    <= bus.key_note;
                noteid_reg <= clamped;
                ovf_reg    <= (bus.key_note > 8'd99);
                busy_reg   <= 1'b1;
            end else begin
                case (state_reg)
                    SHOW: begin
                        if (off_match) begin
                            state_reg <= HOLD;
                            hold_reg  <= HW'(HOLD_CYC - 1);
                        end
                    end
                    HOLD: begin
                        if (hold_reg == '0) begin
                            state_reg  <= IDLE;
                            key_reg    <= 8'd0;
                            noteid_reg <= 8'd0;
                            ovf_reg    <= 1'b0;
                            busy_reg   <= 1'b0;
                        end else begin
                            hold_reg <= hold_reg - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.noteid  = noteid_reg;
    assign bus.seg_out = seg_reg;
    assign bus.dig_sel = dig_reg;
    assign bus.busy    = busy_reg;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-level behavioural model predicts
// every output vector, a monitor compares them as the DUT produces them.
module tb_seg_scan_ctrl;
    localparam int SD = 4;
    localparam int HC = 10;

    logic clk;
    logic rst_n;
    logic [1:0] junk;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.SCAN_DIV(SD), .HOLD_CYC(HC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] dec7(input int d);
        case (d)
            0: return 7'h3f;  1: return 7'h06;  2: return 7'h5b;  3: return 7'h4f;
            4: return 7'h66;  5: return 7'h6d;  6: return 7'h7d;  7: return 7'h07;
            8: return 7'h7f;  9: return 7'h6f;
            default: return 7'h00;
        endcase
    endfunction

    // Reference decoder attached to the DUT's noteid; bit 8 carries noise
    always_comb begin
        bus.seg1 = {junk[0], 1'b0, dec7(int'(bus.noteid) / 10)};
        bus.seg2 = {junk[1], 1'b0, dec7(int'(bus.noteid) % 10)};
    end

    // Model: mode 0 idle, 1 showing, 2 held after release
    int         m_mode;
    logic [7:0] m_key;
    int         m_left;
    int         m_t;

    typedef struct packed {
        logic [7:0] noteid;
        logic [7:0] seg;
        logic [1:0] dig;
        logic       busy;
    } vec_t;

    vec_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    event mon_ev;

    localparam vec_t RESET_VEC = '{noteid: 8'd0, seg: 8'd0, dig: 2'b11, busy: 1'b0};

    function automatic logic [7:0] m_noteid();
        if (m_mode == 0) return 8'd0;
        return (m_key > 8'd99) ? 8'd99 : m_key;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_key  = 8'd0;
        m_left = 0;
        m_t    = 0;
    endtask

    task automatic check_now(input string what, input logic [7:0] w_noteid,
                             input logic [7:0] w_seg, input logic [1:0] w_dig,
                             input logic w_busy);
        if (bus.noteid !== w_noteid || bus.seg_out !== w_seg ||
            bus.dig_sel !== w_dig || bus.busy !== w_busy) begin
            miscompares++;
            $display("FAIL %s t=%0t got noteid=%0d seg=%h dig=%b busy=%b want noteid=%0d seg=%h dig=%b busy=%b",
                     what, $time, bus.noteid, bus.seg_out, bus.dig_sel, bus.busy,
                     w_noteid, w_seg, w_dig, w_busy);
        end else begin
            $display("t=%0t check %s ok", $time, what);
        end
    endtask

    task automatic predict(input logic ko, input logic kf, input logic [7:0] kn);
        vec_t       e;
        int         slot_pos;
        bit         tens;
        logic [7:0] nid;
        bit         ovf;
        slot_pos = m_t % SD;
        tens     = ((m_t / SD) % 2) == 0;
        nid      = m_noteid();
        ovf      = (m_mode != 0) && (m_key > 8'd99);
        if (m_mode == 0 || slot_pos == 0 || (tens && nid < 8'd10)) begin
            e.seg = 8'd0;  e.dig = 2'b11;
        end else if (tens) begin
            e.seg = {ovf, dec7(int'(nid) / 10)};  e.dig = 2'b01;
        end else begin
            e.seg = {1'b0, dec7(int'(nid) % 10)}; e.dig = 2'b10;
        end
        if (ko && kn != 8'd0) begin
            m_key  = kn;
            m_mode = 1;
        end else if (m_mode == 1 && kf && kn == m_key) begin
            m_mode = 2;
            m_left = HC;
        end else if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = 0;
                m_key  = 8'd0;
            end
        end
        m_t++;
        e.noteid = m_noteid();
        e.busy   = (m_mode != 0);
        q.push_back(e);
    endtask

    task automatic step(input logic ko, input logic kf, input logic [7:0] kn, input logic rst_v);
        @(negedge clk);
        rst_n        = rst_v;
        bus.key_on   = ko;
        bus.key_off  = kf;
        bus.key_note = kn;
        junk         = 2'($urandom);
        if (ko || kf)
            $display("t=%0t key_on=%0b key_off=%0b note=%0d", $time, ko, kf, kn);
        if (!rst_v) begin
            model_reset();
            q.push_back(RESET_VEC);
        end else begin
            predict(ko, kf, kn);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 1'b1);
    endtask

    // Asynchronous reset between edges: checked immediately, then at the next edge
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst_n       = 1'b0;
        bus.key_on  = 1'b0;
        bus.key_off = 1'b0;
        model_reset();
        q.push_back(RESET_VEC);
        q.push_back(RESET_VEC);
        $display("t=%0t async reset asserted", $time);
        -> mon_ev;
    endtask

    always begin
        vec_t e;
        @(posedge clk or mon_ev);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (bus.noteid !== e.noteid || bus.seg_out !== e.seg ||
                bus.dig_sel !== e.dig || bus.busy !== e.busy) begin
                miscompares++;
                $display("FAIL outputs t=%0t got noteid=%0d seg=%h dig=%b busy=%b want noteid=%0d seg=%h dig=%b busy=%b",
                         $time, bus.noteid, bus.seg_out, bus.dig_sel, bus.busy,
                         e.noteid, e.seg, e.dig, e.busy);
            end
        end
    end

    initial begin
        logic [7:0] kn;
        logic       ko, kf;
        rst_n        = 1'b1;
        bus.key_on   = 1'b0;
        bus.key_off  = 1'b0;
        bus.key_note = 8'd0;
        junk         = 2'b00;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        q.push_back(RESET_VEC);
        -> mon_ev;
        check_now("reset-state", 8'd0, 8'd0, 2'b11, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0);

        // Show 60, ignore a foreign release, then release and let it expire
        step(1'b1, 1'b0, 8'd60, 1'b1);
        idle(10);
        step(1'b0, 1'b1, 8'd61, 1'b1);
        idle(4);
        step(1'b0, 1'b1, 8'd60, 1'b1);
        idle(14);
        check_now("hold-expired", 8'd0, 8'd0, 2'b11, 1'b0);

        // Single digit, overflow clamp, zero notes ignored
        step(1'b1, 1'b0, 8'd0, 1'b1);
        idle(2);
        step(1'b1, 1'b0, 8'd5, 1'b1);
        idle(9);
        step(1'b1, 1'b0, 8'd127, 1'b1);
        idle(9);
        step(1'b1, 1'b0, 8'd0, 1'b1);
        idle(2);
        step(1'b0, 1'b1, 8'd127, 1'b1);
        idle(13);

        // Re-press during hold, then simultaneous on/off
        step(1'b1, 1'b0, 8'd60, 1'b1);
        idle(3);
        step(1'b0, 1'b1, 8'd60, 1'b1);
        idle(6);
        step(1'b1, 1'b0, 8'd72, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 8'd60, 1'b1);
        idle(2);
        step(1'b1, 1'b1, 8'd64, 1'b1);
        idle(3);
        step(1'b1, 1'b1, 8'd64, 1'b1);
        idle(3);
        step(1'b0, 1'b1, 8'd64, 1'b1);
        idle(3);

        // Reset in the middle of a hold abandons the note
        mid_reset();
        #1;
        check_now("mid-reset", 8'd0, 8'd0, 2'b11, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        idle(8);
        step(1'b1, 1'b0, 8'd42, 1'b1);
        idle(3);
        step(1'b0, 1'b1, 8'd42, 1'b1);
        idle(3);
        mid_reset();
        #1;
        check_now("mid-hold-reset", 8'd0, 8'd0, 2'b11, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        idle(10);

        // Random key traffic
        for (int i = 0; i < 800; i++) begin
            int r;
            r  = int'($urandom_range(0, 9));
            kn = (r == 0) ? 8'd0 :
                 (r == 1) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(1, 99));
            ko = ($urandom_range(0, 9) == 0);
            kf = ($urandom_range(0, 7) == 0);
            if (kf && $urandom_range(0, 1) == 1) kn = m_key;
            step(ko, kf, kn, 1'b1);
        end
        idle(2);
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares == 0) $display("PASS");
        else                  $display("FAIL");
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit time-slot, including the dead cycle (minimum 2).
REQ-002 SHALL have parameter HOLD_CYC, default 25000000: clock cycles a released note stays displayed (minimum 1).
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port key_on  input  1  one-cycle pulse: key pressed, note on key_note.
REQ-006 SHALL have port key_off  input  1  one-cycle pulse: key released, note on key_note.
REQ-007 SHALL have port key_note  input  8  MIDI note number qualifying key_on/key_off.
REQ-008 SHALL have port noteid  output  8  note presented to the two-digit segment decoder; 0 means blank.
REQ-009 SHALL have port seg1  input  9  decoder pattern for the tens digit; bits 7:0 = DP,G,F,E,D,C,B,A, active-high.
REQ-010 SHALL have port seg2  input  9  decoder pattern for the units digit, same encoding.
REQ-011 SHALL have port seg_out  output  8  shared segment bus DP..A, active-high.
REQ-012 SHALL have port dig_sel  output  2  digit enables, active-low; bit1 = tens, bit0 = units.
REQ-013 SHALL have port busy  output  1  high in SHOW or HOLD.

Function
REQ-014 SHALL implement an FSM with states IDLE, SHOW and HOLD.
REQ-015 IDLE + key_on with key_note != 0 SHALL go to SHOW and latch the note; key_on with key_note == 0 SHALL be ignored in every state.
REQ-016 SHOW + key_on (valid note) SHALL replace the latched note and stay in SHOW.
REQ-017 SHOW + key_off with key_note equal to the latched note SHALL go to HOLD and load the hold counter with HOLD_CYC-1; a non-matching key_off SHALL be ignored.
REQ-018 HOLD + key_on (valid note) SHALL latch the new note and go to SHOW; HOLD + key_off SHALL be ignored.
REQ-019 HOLD SHALL decrement the hold counter each cycle and, on the cycle it reads 0, go to IDLE and clear the latched note.
REQ-020 When key_on and key_off are high in the same cycle, key_on SHALL take priority and key_off SHALL be discarded.
REQ-021 Latched notes above 99 SHALL be clamped to 99 and the overflow flag set; a latched note of 99 or below SHALL clear the flag.
REQ-022 noteid SHALL be a register equal to the latched (clamped) note, or 0 in IDLE, updated at the same edge as the state change (1-cycle latency from key_on).
REQ-023 A free-running scan counter 0..SCAN_DIV-1 SHALL toggle the active digit at terminal count, starting with tens after reset.
REQ-024 The counter SHALL run in every state; the first cycle of each slot SHALL be a dead cycle with dig_sel = 2'b11 and seg_out = 0.
REQ-025 On other cycles, seg_out SHALL be registered from seg1[7:0] (tens slot) or seg2[7:0] (units slot), and dig_sel SHALL be 2'b01 or 2'b10 respectively.
REQ-026 In the tens slot with the overflow flag set, seg_out bit7 (DP) SHALL be forced to 1.
REQ-027 The tens digit SHALL be blanked (dig_sel = 2'b11, seg_out = 0) when noteid < 10.
REQ-028 In IDLE, dig_sel SHALL be 2'b11 and seg_out SHALL be 0 on every cycle.
REQ-029 Bit 8 of seg1 and seg2 SHALL be ignored.

Reset
REQ-030 rst_n low SHALL, without waiting for a clock edge, force: state IDLE, noteid 0, seg_out 0, dig_sel 2'b11, busy 0, scan counter 0, tens slot, hold counter 0, overflow flag 0.
REQ-031 Reset asserted mid-SHOW or mid-HOLD SHALL abandon the note; after release, display SHALL resume only on a new key_on.

Verification (SCAN_DIV=4, HOLD_CYC=10, reference decoder attached)
REQ-032 key_on, note 60 -> next cycle noteid=60, busy=1; tens slot seg_out=8'h7d with dig_sel=2'b01, units slot seg_out=8'h3f with dig_sel=2'b10, each slot preceded by 1 dead cycle.
REQ-033 key_on 60, then key_off 60 -> displays 60 for 10 more cycles, then noteid=0, dig_sel=2'b11, busy=0; key_off 61 instead -> stays in SHOW.
REQ-034 key_on 5 -> tens slot blank (dig_sel=2'b11), units slot seg_out=8'h6d; key_on 127 -> noteid=99, tens seg_out=8'hef (DP set), units seg_out=8'h6f.
REQ-035 In HOLD at counter 3, key_on 72 -> next cycle noteid=72, state SHOW; same-cycle key_on 64 + key_off 60 while showing 60 -> noteid=64, no HOLD entry.
REQ-036 rst_n low mid-HOLD between clock edges -> outputs reach reset values immediately; after release, no display until key_on.
